// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// Tracks one req/ack fetch at a time and hands fetched words to decode under stall/redirect.
module fetch_pc_unit #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      INSTR_WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      STEP        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       next_pc_in,
  input  logic                   redirect,
  input  logic                   stall,
  output logic [WIDTH-1:0]       pc_plus_step,
  output logic                   imem_req,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0]       instr_pc,
  output logic                   instr_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       pc_q, pc_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]       ipc_q, ipc_d;
  logic                   valid_q, valid_d;

  // Sequential increment wraps modulo 2^WIDTH
  assign pc_plus_step = pc_q + WIDTH'(STEP);

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      S_REQ: begin
        if (imem_ack && !redirect) begin
          instr_d = imem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          pc_d    = next_pc_in;
          req_d   = 1'b0;
          state_d = S_HOLD;
        end else if (imem_ack && redirect) begin
          // Returned word belongs to the abandoned path; reissue at the target
          pc_d    = next_pc_in;
          addr_d  = next_pc_in;
        end else if (redirect) begin
          pc_d    = next_pc_in;
          state_d = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = next_pc_in;
          addr_d  = next_pc_in;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        // Stale request must run to completion before the real fetch is issued
        if (imem_ack) begin
          state_d = S_REQ;
          if (redirect) begin
            pc_d   = next_pc_in;
            addr_d = next_pc_in;
          end else begin
            addr_d = pc_q;
          end
        end else if (redirect) begin
          pc_d = next_pc_in;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios then random traffic against a flag-based model.
module tb_fetch_pc_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  next_pc_in;
  logic          redirect;
  logic          stall;
  logic [W-1:0]  pc_plus_step;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr_out;
  logic [W-1:0]  instr_pc;
  logic          instr_valid;
  logic [W-1:0]  target;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending request, stale-response flag, held instruction
  logic [W-1:0]  m_pc;
  logic          m_req;
  logic          m_stale;
  logic [W-1:0]  m_addr;
  logic          m_valid;
  logic [IW-1:0] m_out;
  logic [W-1:0]  m_ipc;

  // Next-PC mux external to the unit
  assign next_pc_in = redirect ? target : pc_plus_step;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .WIDTH(W), .INSTR_WIDTH(IW), .RESET_PC(8'h10), .STEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .next_pc_in(next_pc_in), .redirect(redirect),
    .stall(stall), .pc_plus_step(pc_plus_step), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h10; m_req = 1'b0; m_stale = 1'b0; m_addr = 8'h10;
    m_valid = 1'b0; m_out = '0; m_ipc = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] npc;
    npc = redirect ? target : W'(m_pc + 8'd1);
    if (!m_req && !m_valid) begin
      m_req = 1'b1; m_addr = m_pc;
    end else if (m_req && !m_stale) begin
      if (imem_ack && !redirect) begin
        m_out = imem_rdata; m_ipc = m_addr; m_valid = 1'b1; m_pc = npc; m_req = 1'b0;
      end else if (imem_ack) begin
        m_pc = npc; m_addr = npc;
      end else if (redirect) begin
        m_pc = npc; m_stale = 1'b1;
      end
    end else if (m_req) begin
      if (imem_ack) begin
        m_addr = redirect ? npc : m_pc;
        if (redirect) m_pc = npc;
        m_stale = 1'b0;
      end else if (redirect) begin
        m_pc = npc;
      end
    end else begin
      if (redirect) begin
        m_valid = 1'b0; m_pc = npc; m_addr = npc; m_req = 1'b1;
      end else if (!stall) begin
        m_valid = 1'b0; m_addr = m_pc; m_req = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr_out", 32'(instr_out), 32'(m_out));
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    chk("pc_plus_step", 32'(pc_plus_step), 32'(W'(m_pc + 8'd1)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h10);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_out"}, 32'(instr_out), 32'h0);
    chk({tag, "_ipc"}, 32'(instr_pc), 32'h0);
    chk({tag, "_pps"}, 32'(pc_plus_step), 32'h11);
  endtask

  task automatic step(input logic ack, input logic [IW-1:0] data, input logic redir,
                      input logic [W-1:0] tgt, input logic st);
    imem_ack = ack; imem_rdata = data; redirect = redir; target = tgt; stall = st;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    target = '0; stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release and first request
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", 32'(imem_addr), 32'h10);
    chk("t1_pps", 32'(pc_plus_step), 32'h11);

    // Sequential fetch, latency 1 then 3
    step(1'b1, 16'h1111, 1'b0, 8'h0, 1'b0);
    chk("t2_ipc0", 32'(instr_pc), 32'h10);
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    chk("t2_addr1", 32'(imem_addr), 32'h11);
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 8'h0, 1'b0);
    chk("t2_out1", 32'(instr_out), 32'h2222);
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    chk("t2_addr2", 32'(imem_addr), 32'h12);

    // Stall holds presented word
    step(1'b1, 16'hABCD, 1'b0, 8'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
      chk("t3_out", 32'(instr_out), 32'hABCD);
      chk("t3_req", 32'(imem_req), 32'h0);
    end
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    chk("t3_valid", 32'(instr_valid), 32'h0);
    chk("t3_addr", 32'(imem_addr), 32'h13);

    // Redirect with request pending
    step(1'b0, 16'h0, 1'b1, 8'h40, 1'b0);
    chk("t4_hold_addr", 32'(imem_addr), 32'h13);
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 8'h0, 1'b0);
    chk("t4_drop_valid", 32'(instr_valid), 32'h0);
    chk("t4_addr", 32'(imem_addr), 32'h40);
    step(1'b1, 16'h4444, 1'b0, 8'h0, 1'b0);
    chk("t4_ipc", 32'(instr_pc), 32'h40);

    // Redirect coinciding with ack, then redirect in stalled hold
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 8'h80, 1'b0);
    chk("t5_valid", 32'(instr_valid), 32'h0);
    chk("t5_addr", 32'(imem_addr), 32'h80);
    step(1'b1, 16'h8888, 1'b0, 8'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 8'h90, 1'b1);
    chk("t5_hold_valid", 32'(instr_valid), 32'h0);
    chk("t5_hold_addr", 32'(imem_addr), 32'h90);
    step(1'b1, 16'h9999, 1'b0, 8'h0, 1'b0);

    // PC wrap
    step(1'b0, 16'h0, 1'b1, 8'hFF, 1'b1);
    chk("t6_pps", 32'(pc_plus_step), 32'h00);
    step(1'b1, 16'h1234, 1'b0, 8'h0, 1'b0);
    chk("t6_ipc", 32'(instr_pc), 32'hFF);
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    chk("t6_addr", 32'(imem_addr), 32'h00);

    // Asynchronous reset mid-request
    #3 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, including acks outside a request
    for (int i = 0; i < 3000; i++) begin
      step(m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
           IW'($urandom), $urandom_range(0, 5) == 0, W'($urandom),
           $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
